switch_ram_scan: RTL and testbench
==================================

# switch_ram_scan

Small writable 4-word × 4-bit memory with a registered read port and an optional auto-scan read pointer. It sits directly upstream of the LED[7:4] nibble display in `top`, replacing the fixed address→nibble lookup with storage that the switches can rewrite. Reset loads the same four constants the lookup uses (3, 2, 9, C). Switch-driven writes are edge-qualified so one lever flip produces exactly one write.

## Interface
Parameters:
- `NWORDS`, 4: number of words; must be a power of two.
- `WIDTH`, 4: bits per word.
- `SCAN_DIV`, 4: clk_2 cycles per scan step; must be ≥ 1.

Ports:
- `clk_2`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk_2`.
- `addr`  in  $clog2(NWORDS)  write address; also the read address when `scan`=0 (driven from SWI[3:2]).
- `wdata`  in  WIDTH  write data (driven from SWI[7:4]).
- `we`  in  1  write lever, level input; a write occurs only on its 0→1 transition.
- `scan`  in  1  1 = read pointer auto-increments; 0 = read pointer follows `addr`.
- `rdata`  out  WIDTH  registered read data (feeds LED[7:4]).
- `raddr`  out  $clog2(NWORDS)  address that `rdata` was read from.
- `wr_ack`  out  1  one-cycle pulse in the cycle a write commits.
- `dirty`  out  NWORDS  bit i = word i has been written since reset.

## Operation
- Reset (`reset_n`=0 at an edge):
  - mem ← {3, 2, 9, C} for words 0..3.
  - `rdata`=3, `raddr`=0, `wr_ack`=0, `dirty`=0.
  - Scan pointer and divider = 0; `we_q` = 1, so a lever already high at reset does not write.
- Write detect: `we_rise = we & ~we_q`; `we_q` ← `we` every cycle.
- On `we_rise`:
  - mem[addr] ← `wdata`.
  - `dirty[addr]` ← 1.
  - `wr_ack`=1 for the next cycle only.
  - Holding `we` high does not produce further writes.
- Read address selection:
  - `scan`=0: read address = `addr`.
  - `scan`=1: read address = scan pointer `sp`.
- Scan:
  - Divider counts 0..SCAN_DIV-1; on the cycle it reaches SCAN_DIV-1 it returns to 0 and `sp` increments.
  - `sp` wraps NWORDS-1 → 0.
  - Divider and `sp` are frozen while `scan`=0.
  - On a 0→1 transition of `scan`, `sp` loads the current `addr` and the divider clears.
- Read-during-write is write-first: if a write and a read hit the same address in the same cycle, `rdata` shows the new `wdata`.
- Writes always use `addr`, including in scan mode.
- All address arithmetic is modulo NWORDS; no out-of-range state exists.

## Timing
- Read latency is 1 cycle: the address in effect at edge N produces `rdata` and `raddr` after edge N.
- A write committed at edge N:
  - `wr_ack` is high from edge N until edge N+1.
  - `dirty` updates at edge N.
- Scan step period is SCAN_DIV cycles. `raddr` changes one cycle after `sp` changes.
- Reset has priority over every event. A reset during a write cycle discards the write and gives no `wr_ack`.
- Simultaneous `we_rise` and a `scan` rise: both take effect in the same cycle.

## Structure
- Package `ram_scan_pkg` holds:
  - `NWORDS` and `WIDTH` defaults.
  - typedef `word_t` (logic [WIDTH-1:0]).
  - constant array `RAM_INIT` = {4'h3, 4'h2, 4'h9, 4'hC}.
- Sub-module `rise_detect` (clk_2, reset_n, in, out pulse; reset value of the internal register selectable by parameter) is instantiated twice: for `we` and for `scan`.
- Memory is a flop array, not inferred block RAM, so reset can initialise it.

## Test plan
- Reset, `scan`=0, step `addr` 0,1,2,3 → `rdata` = 3, 2, 9, C one cycle after each step; `dirty`=0000.
- `addr`=2, `wdata`=5, `we` 0→1 held high for 10 cycles → exactly one `wr_ack` pulse; mem[2]=5; `dirty`=0100; reading addr 2 gives 5.
- `we` high during reset, then release reset → no write and no `wr_ack`; word 0 still reads 3.
- `scan`=1 with `addr`=3, SCAN_DIV=4 → `raddr` sequence 3,3,3,3,0,0,0,0,1… (each value held 4 cycles, wrapping 3→0).
- Write `wdata`=A to addr 1 in the same cycle the read address is 1 → next-cycle `rdata`=A (write-first).
- After several writes, assert `reset_n`=0 for one cycle → contents back to 3, 2, 9, C; `dirty`=0000; `sp`=0.

Source files
------------

// File: rtl/switch_ram_scan_pkg.sv
// ram_scan_pkg: shared sizes, word type and power-on contents for switch_ram_scan.
package ram_scan_pkg;
    localparam int NWORDS = 4;
    localparam int WIDTH  = 4;
    typedef logic [WIDTH-1:0] word_t;
    localparam word_t RAM_INIT [NWORDS] = '{4'h3, 4'h2, 4'h9, 4'hC};
    function automatic word_t init_word(input int i);
        return RAM_INIT[2'(i)];
    endfunction
endpackage

// File: rtl/switch_ram_scan_rise_detect.sv
// rise_detect: one-cycle pulse on a 0->1 transition of a level input.
module rise_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic in_i,
    output logic pulse_o
);
    logic in_q;
    always_ff @(posedge clk_2) in_q <= !reset_n ? RST_VAL : in_i;
    assign pulse_o = in_i & ~in_q;
endmodule

// File: rtl/switch_ram_scan.sv
// switch_ram_scan: switch-writable nibble store with registered read port and auto-scan pointer.
module switch_ram_scan #(
    parameter int NWORDS   = ram_scan_pkg::NWORDS,
    parameter int WIDTH    = ram_scan_pkg::WIDTH,
    parameter int SCAN_DIV = 4
) (
    input  logic                      clk_2,
    input  logic                      reset_n,
    input  logic [$clog2(NWORDS)-1:0] addr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      we,
    input  logic                      scan,
    output logic [WIDTH-1:0]          rdata,
    output logic [$clog2(NWORDS)-1:0] raddr,
    output logic                      wr_ack,
    output logic [NWORDS-1:0]         dirty
);
    import ram_scan_pkg::*;
    localparam int AW = $clog2(NWORDS);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    logic [WIDTH-1:0] mem [NWORDS];
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [AW-1:0]    sp_q, sp_d, raddr_q, rd_addr;
    logic [DW-1:0]    div_q, div_d;
    logic             wr_ack_q, we_rise, scan_rise, step;
    // the write lever resets as "already high" so a lever up through reset never writes
    rise_detect #(.RST_VAL(1'b1)) u_we_rise (
        .clk_2(clk_2), .reset_n(reset_n), .in_i(we), .pulse_o(we_rise)
    );
    rise_detect #(.RST_VAL(1'b0)) u_scan_rise (
        .clk_2(clk_2), .reset_n(reset_n), .in_i(scan), .pulse_o(scan_rise)
    );
    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        logic [WIDTH-1:0] word_q;
        logic             dirty_q;
        always_ff @(posedge clk_2) begin
            if (!reset_n) begin
                word_q  <= WIDTH'(init_word(i));
                dirty_q <= 1'b0;
            end else if (we_rise && addr == AW'(i)) begin
                word_q  <= wdata;
                dirty_q <= 1'b1;
            end
        end
        assign mem[i]   = word_q;
        assign dirty[i] = dirty_q;
    end
    assign step    = div_q == DW'(SCAN_DIV - 1);
    assign rd_addr = scan ? sp_q : addr;
    always_comb begin
        sp_d    = scan_rise ? addr : (scan && step) ? sp_q + 1'b1 : sp_q;
        div_d   = (scan_rise || (scan && step)) ? '0 : scan ? div_q + 1'b1 : div_q;
        rdata_d = (we_rise && addr == rd_addr) ? wdata : mem[rd_addr];
    end
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            sp_q     <= '0;
            div_q    <= '0;
            raddr_q  <= '0;
            rdata_q  <= WIDTH'(init_word(0));
            wr_ack_q <= 1'b0;
        end else begin
            sp_q     <= sp_d;
            div_q    <= div_d;
            raddr_q  <= rd_addr;
            rdata_q  <= rdata_d;
            wr_ack_q <= we_rise;
        end
    end
    assign rdata  = rdata_q;
    assign raddr  = raddr_q;
    assign wr_ack = wr_ack_q;
endmodule

// File: tb/tb_switch_ram_scan.sv
// tb_switch_ram_scan: directed table, scan sequence and randomized run against a spec-level model.
module tb_switch_ram_scan;
    localparam int SD = 4;
    logic       clk_2 = 1'b0, reset_n = 1'b0, we = 1'b0, scan = 1'b0, wr_ack;
    logic [1:0] addr = '0, raddr;
    logic [3:0] wdata = '0, rdata, dirty;
    int n_vec = 0, n_bad = 0;

    switch_ram_scan #(.NWORDS(4), .WIDTH(4), .SCAN_DIV(SD)) dut (
        .clk_2(clk_2), .reset_n(reset_n), .addr(addr), .wdata(wdata), .we(we),
        .scan(scan), .rdata(rdata), .raddr(raddr), .wr_ack(wr_ack), .dirty(dirty)
    );

    always #5 clk_2 = ~clk_2;

    // model: contents, dirty set, lever/scan history, and the pointer as base + elapsed scan steps
    int m_mem [4];
    int m_dirty, m_we_q, m_scan_q, m_base, m_n, e_rdata, e_raddr, e_ack;

    task automatic model_step();
        logic [1:0] ra;
        logic       wr, srise;
        if (!reset_n) begin
            m_mem = '{3, 2, 9, 12};
            m_dirty = 0; m_we_q = 1; m_scan_q = 0; m_base = 0; m_n = 0;
            e_rdata = 3; e_raddr = 0; e_ack = 0;
        end else begin
            wr    = we && m_we_q == 0;
            srise = scan && m_scan_q == 0;
            ra    = scan ? 2'((m_base + m_n / SD) % 4) : addr;
            if (wr) begin
                m_mem[addr] = int'(wdata);
                m_dirty = m_dirty | (1 << addr);
            end
            e_rdata = m_mem[ra];
            e_raddr = int'(ra);
            e_ack   = int'(wr);
            if (srise) begin
                m_base = int'(addr);
                m_n = 0;
            end else if (scan) m_n++;
            m_we_q   = int'(we);
            m_scan_q = int'(scan);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " rdata"}, 32'(rdata), e_rdata);
        chk({tag, " raddr"}, 32'(raddr), e_raddr);
        chk({tag, " wr_ack"}, 32'(wr_ack), e_ack);
        chk({tag, " dirty"}, 32'(dirty), m_dirty);
    endtask

    typedef struct {
        int rst_n, a, d, w, s, rd, ra, ack, dt;
    } vec_t;
    vec_t tbl [15];
    int   scan_seq [12];

    initial begin
        tbl = '{
            '{0, 0,  0, 0, 0,  3, 0, 0, 0},
            '{1, 0,  0, 0, 0,  3, 0, 0, 0},
            '{1, 1,  0, 0, 0,  2, 1, 0, 0},
            '{1, 2,  0, 0, 0,  9, 2, 0, 0},
            '{1, 3,  0, 0, 0, 12, 3, 0, 0},
            '{1, 2,  5, 1, 0,  5, 2, 1, 4},
            '{1, 2,  5, 1, 0,  5, 2, 0, 4},
            '{1, 2,  5, 1, 0,  5, 2, 0, 4},
            '{1, 1, 10, 0, 0,  2, 1, 0, 4},
            '{1, 1, 10, 1, 0, 10, 1, 1, 6},
            '{1, 0, 15, 1, 0,  3, 0, 0, 6},
            '{0, 0, 15, 1, 0,  3, 0, 0, 0},
            '{1, 0, 15, 1, 0,  3, 0, 0, 0},
            '{1, 2,  0, 1, 0,  9, 2, 0, 0},
            '{1, 1,  0, 0, 0,  2, 1, 0, 0}
        };
        scan_seq = '{0, 3, 3, 3, 3, 0, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 15; i++) begin
            reset_n = 1'(tbl[i].rst_n);
            addr    = 2'(tbl[i].a);
            wdata   = 4'(tbl[i].d);
            we      = 1'(tbl[i].w);
            scan    = 1'(tbl[i].s);
            tick();
            chk($sformatf("row%0d rdata", i), 32'(rdata), tbl[i].rd);
            chk($sformatf("row%0d raddr", i), 32'(raddr), tbl[i].ra);
            chk($sformatf("row%0d wr_ack", i), 32'(wr_ack), tbl[i].ack);
            chk($sformatf("row%0d dirty", i), 32'(dirty), tbl[i].dt);
        end
        // scan from addr 3: first cycle still reads the reset pointer, then 3 x4, 0 x4, 1...
        addr = 2'd3;
        tick();
        scan = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("scan%0d raddr", k), 32'(raddr), scan_seq[k]);
            chk($sformatf("scan%0d model", k), 32'(rdata), e_rdata);
            addr = 2'd0;
        end
        // pointer frozen while scan is low, then write to the address being scanned
        scan = 1'b0; addr = 2'd2;
        tick();
        chk_model("freeze");
        scan = 1'b1; addr = 2'd1; wdata = 4'hA; we = 1'b0;
        tick();
        we = 1'b1;
        tick();
        chk_model("scanwr");
        for (int k = 0; k < 400; k++) begin
            reset_n = $urandom_range(39) != 0;
            if ($urandom_range(2) == 0) we = ~we;
            if ($urandom_range(7) == 0) scan = ~scan;
            addr  = 2'($urandom);
            wdata = 4'($urandom);
            tick();
            chk_model($sformatf("rnd%0d", k));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
